cluster_unpacker_1536: RTL and testbench

//  Receive end of the first-8 cluster finder: takes one frame of 8 {adr,cnt} clusters and rebuilds
//  the 1536-pad partition view (cluster-start flags, per-pad counts, full pad-hit mask).

---
 rtl/cluster_unpacker_1536_pkg.sv | 24 ++
 rtl/cluster_pad_mask.sv | 29 ++
 rtl/cluster_unpacker_1536.sv | 107 ++++++++++
 tb/tb_cluster_unpacker_1536.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_unpacker_1536_pkg.sv
// Shared constants and state encoding for the cluster unpacker.
package cluster_unpacker_1536_pkg;

    localparam int NPADS  = 1536;
    localparam int NCLUST = 8;
    localparam int ADRB   = 11;
    localparam int CNTB   = 3;

    // Pad count as an address-width value, for comparing against slot addresses
    localparam logic [ADRB-1:0] NPADS_ADR = 11'd1536;

    // Codes the finder uses to mark an empty slot; any adr >= NPADS is treated the same way
    localparam logic [ADRB-1:0] ADR_EMPTY_A = 11'h7FE;
    localparam logic [ADRB-1:0] ADR_EMPTY_B = 11'h7FF;

    localparam logic [2:0] SLOT_LAST = 3'(NCLUST - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/cluster_pad_mask.sv
// Combinational range mask: one bit per pad covered by a cluster of cnt+1 pads
// starting at adr. Pads past the end of the partition are dropped (no wrap).
module cluster_pad_mask
    import cluster_unpacker_1536_pkg::*;
(
    input  logic [ADRB-1:0]  adr,
    input  logic [CNTB-1:0]  cnt,
    output logic [NPADS-1:0] mask
);

    logic [ADRB:0] lo;
    logic [ADRB:0] hi;
    logic [ADRB:0] pad_idx;
    logic          slot_used;

    // Compare every pad index against [adr, adr+cnt]; one extra bit keeps adr+cnt from wrapping
    always_comb begin
        lo        = {1'b0, adr};
        hi        = lo + {{(ADRB + 1 - CNTB){1'b0}}, cnt};
        slot_used = (adr < NPADS_ADR);
        pad_idx   = '0;
        mask      = '0;
        for (int p = 0; p < NPADS; p++) begin
            pad_idx = p[ADRB:0];
            mask[p] = slot_used && (pad_idx >= lo) && (pad_idx <= hi);
        end
    end

endmodule

// File: rtl/cluster_unpacker_1536.sv
// Rebuilds the 1536-pad view (start flags, per-pad counts, hit mask) from one
// frame of 8 {adr,cnt} clusters, expanding one slot per clock4x cycle.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no frame in flight, outputs hold last result, ready
//   ST_EXPAND | applying slot 0..7 of the latched frame, one per cycle
//   ST_DONE   | result complete, out_valid pulse, ready for next frame
module cluster_unpacker_1536
    import cluster_unpacker_1536_pkg::*;
(
    input  logic                     clock4x,
    input  logic                     global_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCLUST*ADRB-1:0]   in_adr,
    input  logic [NCLUST*CNTB-1:0]   in_cnt,
    output logic [NPADS-1:0]         vpfs,
    output logic [NPADS*CNTB-1:0]    cnts,
    output logic [NPADS-1:0]         pads,
    output logic [3:0]               nclusters,
    output logic                     out_valid,
    output logic                     busy
);

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             slot;
    logic [NCLUST*ADRB-1:0] adr_q;
    logic [NCLUST*CNTB-1:0] cnt_q;
    logic [ADRB-1:0]        cur_adr;
    logic [CNTB-1:0]        cur_cnt;
    logic                   cur_hit;
    logic [NPADS-1:0]       cur_mask;
    logic                   accept;

    assign accept  = in_valid && in_ready;
    assign cur_adr = adr_q[slot*ADRB +: ADRB];
    assign cur_cnt = cnt_q[slot*CNTB +: CNTB];
    assign cur_hit = (cur_adr < NPADS_ADR);

    cluster_pad_mask u_pad_mask (
        .adr  (cur_adr),
        .cnt  (cur_cnt),
        .mask (cur_mask)
    );

    // Next state and state-decoded handshake/status outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_EXPAND;
            end
            ST_EXPAND: begin
                busy = 1'b1;
                if (slot == SLOT_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                state_nxt = in_valid ? ST_EXPAND : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) state <= ST_IDLE;
        else              state <= state_nxt;
    end

    // Frame latch, slot counter and output accumulators; accept clears the previous result
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            adr_q     <= '0;
            cnt_q     <= '0;
            slot      <= '0;
            vpfs      <= '0;
            cnts      <= '0;
            pads      <= '0;
            nclusters <= '0;
        end else if (accept) begin
            adr_q     <= in_adr;
            cnt_q     <= in_cnt;
            slot      <= '0;
            vpfs      <= '0;
            cnts      <= '0;
            pads      <= '0;
            nclusters <= '0;
        end else if (state == ST_EXPAND) begin
            slot <= slot + 3'd1;
            if (cur_hit) begin
                vpfs[cur_adr]                 <= 1'b1;
                cnts[cur_adr*CNTB +: CNTB]    <= cur_cnt;
                pads                          <= pads | cur_mask;
                nclusters                     <= nclusters + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cluster_unpacker_1536.sv
// Directed bench for cluster_unpacker_1536 with a frame-level reference model
// and a per-cycle comparator.
module tb_cluster_unpacker_1536;

    localparam int NP = 1536;

    logic           clock4x = 1'b0;
    logic           global_reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [87:0]    in_adr = '0;
    logic [23:0]    in_cnt = '0;
    logic [NP-1:0]  vpfs;
    logic [3*NP-1:0] cnts;
    logic [NP-1:0]  pads;
    logic [3:0]     nclusters;
    logic           out_valid;
    logic           busy;

    cluster_unpacker_1536 dut (
        .clock4x      (clock4x),
        .global_reset (global_reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_adr       (in_adr),
        .in_cnt       (in_cnt),
        .vpfs         (vpfs),
        .cnts         (cnts),
        .pads         (pads),
        .nclusters    (nclusters),
        .out_valid    (out_valid),
        .busy         (busy)
    );

    always #5 clock4x = ~clock4x;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int              f_adr[8];
    int              f_cnt[8];
    int              m_phase = -1;     // -1 idle, 0..7 expanding, 8 result cycle
    logic [NP-1:0]   m_vpfs = '0;
    logic [NP-1:0]   m_pads = '0;
    logic [3*NP-1:0] m_cnts = '0;
    int              m_n = 0;
    int              cyc = 0;
    int              acc_t[$];

    function automatic void model_frame();
        int a, c;
        m_vpfs = '0; m_pads = '0; m_cnts = '0; m_n = 0;
        for (int k = 0; k < 8; k++) begin
            a = int'(in_adr[k*11 +: 11]);
            c = int'(in_cnt[k*3 +: 3]);
            if (a < NP) begin
                m_vpfs[a] = 1'b1;
                m_cnts[a*3 +: 3] = c[2:0];
                for (int p = a; p <= a + c; p++)
                    if (p < NP) m_pads[p] = 1'b1;
                m_n++;
            end
        end
    endfunction

    always @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            m_phase = -1; m_vpfs = '0; m_pads = '0; m_cnts = '0; m_n = 0;
        end else begin
            cyc++;
            if (in_valid && (m_phase < 0 || m_phase == 8)) begin
                acc_t.push_back(cyc);
                model_frame();
                m_phase = 0;
            end else if (m_phase >= 0 && m_phase < 8) begin
                m_phase++;
            end else if (m_phase == 8) begin
                m_phase = -1;
            end
        end
    end

    // Per-cycle comparator; results only compared while they are meant to be stable
    always @(negedge clock4x) begin
        if (!global_reset) begin
            chk("in_ready", int'(in_ready), int'(m_phase < 0 || m_phase == 8));
            chk("busy", int'(busy), int'(m_phase >= 0 && m_phase < 8));
            chk("out_valid", int'(out_valid), int'(m_phase == 8));
            if (m_phase < 0 || m_phase == 8) begin
                chk("nclusters", int'(nclusters), m_n);
                chk("vpfs_diff_bits", $countones(vpfs ^ m_vpfs), 0);
                chk("pads_diff_bits", $countones(pads ^ m_pads), 0);
                chk("cnts_diff_bits", $countones(cnts ^ m_cnts), 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_frame();
        for (int k = 0; k < 8; k++) begin f_adr[k] = 2047; f_cnt[k] = 0; end
    endtask

    task automatic apply_frame();
        for (int k = 0; k < 8; k++) begin
            in_adr[k*11 +: 11] = f_adr[k][10:0];
            in_cnt[k*3 +: 3]   = f_cnt[k][2:0];
        end
    endtask

    // Raise in_valid and return just after the accepting edge (in_valid left high)
    task automatic do_accept();
        int t;
        apply_frame();
        in_valid = 1'b1;
        t = 0;
        while (t < 30) begin
            @(negedge clock4x);
            if (in_ready) break;
            t++;
        end
        if (t >= 30) chk("accept_timeout", 0, 1);
        @(posedge clock4x);
        #2;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clock4x);
            lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) chk("done_timeout", 0, 1);
    endtask

    task automatic send(input string nm);
        int lat;
        do_accept();
        in_valid = 1'b0;
        wait_done(lat);
        chk({nm, "_latency"}, lat, 9);
    endtask

    // ---------------- directed sequence ----------------
    int lat;
    int seen;
    int rv[NP];
    int rc[NP];
    int last_pick, npick, mism, cmism;

    initial begin
        clear_frame();
        apply_frame();
        #1 global_reset = 1'b1;
        repeat (3) @(posedge clock4x);
        #3 global_reset = 1'b0;
        @(negedge clock4x);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_nclusters", int'(nclusters), 0);
        chk("rst_vpfs_ones", $countones(vpfs), 0);
        chk("rst_pads_ones", $countones(pads), 0);

        // reset while slot 4 is being expanded
        clear_frame(); f_adr[0] = 100; f_cnt[0] = 2; f_adr[1] = 300; f_cnt[1] = 4;
        do_accept();
        in_valid = 1'b0;
        seen = 0;
        while (m_phase != 4 && seen < 20) begin @(negedge clock4x); seen++; end
        #3 global_reset = 1'b1;
        repeat (2) @(posedge clock4x);
        #3 global_reset = 1'b0;
        @(negedge clock4x);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_nclusters", int'(nclusters), 0);
        chk("midrst_pads_ones", $countones(pads), 0);
        chk("midrst_vpfs_ones", $countones(vpfs), 0);
        seen = 0;
        repeat (12) begin @(negedge clock4x); if (out_valid) seen = 1; end
        chk("midrst_no_out_valid", seen, 0);

        // single cluster, other slots empty (both empty codes)
        clear_frame(); f_adr[0] = 100; f_cnt[0] = 2; f_adr[5] = 2046; f_cnt[5] = 7;
        send("single");
        chk("single_vpfs100", int'(vpfs[100]), 1);
        chk("single_cnts100", int'(cnts[300 +: 3]), 2);
        chk("single_pads100_102", int'(pads[102:100]), 7);
        chk("single_pads99", int'(pads[99]), 0);
        chk("single_pads103", int'(pads[103]), 0);
        chk("single_nclusters", int'(nclusters), 1);

        // clipping at the top of the partition
        clear_frame(); f_adr[3] = 1534; f_cnt[3] = 7;
        send("clip");
        chk("clip_pads_top", int'(pads[1535:1534]), 3);
        chk("clip_pads0", int'(pads[0]), 0);
        chk("clip_pads_ones", $countones(pads), 2);
        chk("clip_cnts1534", int'(cnts[1534*3 +: 3]), 7);

        // overlapping clusters
        clear_frame(); f_adr[0] = 10; f_cnt[0] = 3; f_adr[1] = 12; f_cnt[1] = 1;
        send("overlap");
        chk("overlap_pads10_13", int'(pads[13:10]), 15);
        chk("overlap_pads14", int'(pads[14]), 0);
        chk("overlap_vpfs", int'({vpfs[12], vpfs[11], vpfs[10]}), 5);
        chk("overlap_nclusters", int'(nclusters), 2);
        chk("overlap_cnts12", int'(cnts[36 +: 3]), 1);

        // duplicate address, later slot wins the count
        clear_frame(); f_adr[0] = 500; f_cnt[0] = 1; f_adr[3] = 500; f_cnt[3] = 5;
        send("dup");
        chk("dup_cnts500", int'(cnts[1500 +: 3]), 5);
        chk("dup_pads500_505", int'(pads[505:500]), 63);
        chk("dup_pads506", int'(pads[506]), 0);
        chk("dup_vpfs_ones", $countones(vpfs), 1);
        chk("dup_nclusters", int'(nclusters), 2);

        // full frame, all eight slots used
        clear_frame();
        for (int k = 0; k < 8; k++) begin f_adr[k] = k * 200 + 3; f_cnt[k] = k; end
        send("full");
        chk("full_nclusters", int'(nclusters), 8);
        chk("full_pads_ones", $countones(pads), 36);

        // back-to-back with in_valid held; bus changes while expanding
        clear_frame(); f_adr[0] = 20; f_cnt[0] = 1; f_adr[1] = 40; f_cnt[1] = 0;
        do_accept();
        clear_frame(); f_adr[0] = 700; f_cnt[0] = 2;
        apply_frame();
        wait_done(lat);
        chk("b2b_a_latency", lat, 9);
        chk("b2b_a_vpfs20", int'(vpfs[20]), 1);
        chk("b2b_a_vpfs700", int'(vpfs[700]), 0);
        @(posedge clock4x);
        #2 in_valid = 1'b0;
        wait_done(lat);
        chk("b2b_b_latency", lat, 9);
        chk("b2b_b_vpfs20", int'(vpfs[20]), 0);
        chk("b2b_b_pads21", int'(pads[21]), 0);
        chk("b2b_b_vpfs700", int'(vpfs[700]), 1);
        chk("b2b_b_nclusters", int'(nclusters), 1);
        if (acc_t.size() >= 2)
            chk("b2b_accept_spacing", acc_t[acc_t.size()-1] - acc_t[acc_t.size()-2], 9);
        else
            chk("b2b_accept_count", acc_t.size(), 2);

        // loopback: first-8 finder emulated on random pad patterns
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NP; p++) begin
                rv[p] = ($urandom_range(0, 199) < 2) ? 1 : 0;
                rc[p] = $urandom_range(0, 7);
            end
            clear_frame();
            npick = 0; last_pick = NP;
            for (int p = 0; p < NP; p++) begin
                if (rv[p] == 1 && npick < 8) begin
                    f_adr[npick] = p; f_cnt[npick] = rc[p];
                    npick++;
                    if (npick == 8) last_pick = p;
                end
            end
            send("loop");
            mism = 0; cmism = 0;
            for (int p = 0; p < NP; p++) begin
                if (int'(vpfs[p]) != ((rv[p] == 1 && p <= last_pick) ? 1 : 0)) mism++;
                if (rv[p] == 1 && p <= last_pick && int'(cnts[p*3 +: 3]) != rc[p]) cmism++;
            end
            chk("loop_start_mismatches", mism, 0);
            chk("loop_cnt_mismatches", cmism, 0);
            chk("loop_nclusters", int'(nclusters), npick);
        end

        repeat (4) @(negedge clock4x);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
